// File: rtl/sum_arb_pkg.sv
// Shared definitions for sum_channel_arbiter and rr_burst_arbiter.
//   ch_w(n)     : channel-id width, max(1, $clog2(n))
//   cnt_w(b)    : burst-counter width able to hold the value b
//   rr_ptr_t    : round-robin pointer type for the default channel count
//   burst_cnt_t : burst-counter type for the default burst length
//   SatAllOnes  : saturation constant; sliced down to the operand width
package sum_arb_pkg;

    localparam int unsigned MaxWidth    = 64;
    localparam int unsigned DefNCh      = 4;
    localparam int unsigned DefBurstLen = 2;

    localparam logic [MaxWidth-1:0] SatAllOnes = '1;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned burst);
        return (burst > 1) ? $clog2(burst + 1) : 1;
    endfunction

    typedef logic [ch_w(DefNCh)-1:0]       rr_ptr_t;
    typedef logic [cnt_w(DefBurstLen)-1:0] burst_cnt_t;

endpackage

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded bursts.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   elig_i        : per-channel eligibility (both operands valid)
//   adv_i         : downstream can accept a beat this cycle; no grant without it
//   grant_o       : one-hot grant (all zero when nothing is granted)
//   grant_idx_o   : encoded index of the granted channel
//   grant_valid_o : a grant is issued this cycle (a transfer happens)
// Owns the rotation pointer, the last granted channel and the burst count.
module rr_burst_arbiter
    import sum_arb_pkg::*;
#(
    parameter int unsigned n_ch      = 4,
    parameter int unsigned burst_len = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [n_ch-1:0]         elig_i,
    input  logic                    adv_i,
    output logic [n_ch-1:0]         grant_o,
    output logic [ch_w(n_ch)-1:0]   grant_idx_o,
    output logic                    grant_valid_o
);

    localparam int unsigned ChW  = ch_w(n_ch);
    localparam int unsigned CntW = cnt_w(burst_len);

    localparam logic [ChW-1:0]  LastIdx  = ChW'(n_ch - 1);
    localparam logic [CntW-1:0] BurstMax = CntW'(burst_len);

    logic [ChW-1:0]  ptr_q, ptr_d;
    logic [ChW-1:0]  last_q, last_d;
    logic [CntW-1:0] count_q, count_d;

    logic           last_elig;
    logic           found;
    logic [ChW-1:0] sel_idx;
    int             idx;

    // Eligibility of the last granted channel, looked up without a variable
    // bit-select so odd channel counts never index past the vector.
    always_comb begin
        last_elig = 1'b0;
        for (int i = 0; i < int'(n_ch); i++) begin
            if (last_q == ChW'(i)) begin
                last_elig = elig_i[i];
            end
        end
    end

    always_comb begin
        found   = 1'b0;
        sel_idx = ptr_q;
        idx     = 0;
        if (adv_i) begin
            if (last_elig && (count_q < BurstMax)) begin
                found   = 1'b1;
                sel_idx = last_q;
            end else begin
                for (int k = 0; k < int'(n_ch); k++) begin
                    idx = int'(ptr_q) + k;
                    if (idx >= int'(n_ch)) begin
                        idx = idx - int'(n_ch);
                    end
                    if (!found && elig_i[idx]) begin
                        found   = 1'b1;
                        sel_idx = ChW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(n_ch); i++) begin
            grant_o[i] = found && (sel_idx == ChW'(i));
        end
    end

    assign grant_idx_o   = sel_idx;
    assign grant_valid_o = found;

    // The pointer always moves past the granted channel. It is only consulted
    // once the burst ends or the last channel drops out, so this matches
    // rotating at burst end without tracking next-cycle eligibility.
    // A wrap back onto the same channel after a full burst starts a new burst.
    always_comb begin
        ptr_d   = ptr_q;
        last_d  = last_q;
        count_d = count_q;
        if (found) begin
            ptr_d  = (sel_idx == LastIdx) ? '0 : sel_idx + 1'b1;
            last_d = sel_idx;
            if ((sel_idx == last_q) && (count_q < BurstMax)) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            last_q  <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sum_channel_arbiter.sv
// Shares one a+b adder between n_ch requester channels.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   a_valid/a_ready    : per-channel a operand handshake
//   a_data             : a operands, channel i at [i*width +: width]
//   b_valid/b_ready    : per-channel b operand handshake
//   b_data             : b operands, same packing
//   sum_valid/ready    : one-entry registered output stage handshake
//   sum_data           : registered a+b
//   sum_ch             : channel id of sum_data
// Build option: define SUM_CHANNEL_ARBITER_SAT_EN to saturate the sum to
// all-ones on unsigned overflow; otherwise the sum wraps modulo 2^width.
module sum_channel_arbiter
    import sum_arb_pkg::*;
#(
    parameter int unsigned width     = 8,
    parameter int unsigned n_ch      = 4,
    parameter int unsigned burst_len = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [n_ch-1:0]         a_valid,
    output logic [n_ch-1:0]         a_ready,
    input  logic [n_ch*width-1:0]   a_data,
    input  logic [n_ch-1:0]         b_valid,
    output logic [n_ch-1:0]         b_ready,
    input  logic [n_ch*width-1:0]   b_data,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic [width-1:0]        sum_data,
    output logic [ch_w(n_ch)-1:0]   sum_ch
);

    localparam int unsigned ChW = ch_w(n_ch);

    logic [n_ch-1:0]  elig;
    logic             can_load;
    logic [n_ch-1:0]  grant;
    logic [ChW-1:0]   grant_idx;
    logic             grant_valid;
    int unsigned      sel_base;
    logic [width-1:0] a_sel, b_sel, sum_res;

    logic             sum_valid_q, sum_valid_d;
    logic [width-1:0] sum_data_q, sum_data_d;
    logic [ChW-1:0]   sum_ch_q, sum_ch_d;

    assign elig = a_valid & b_valid;

    // Reset gates the load enable so no ready is raised while rst_n is low.
    assign can_load = (~sum_valid_q | sum_ready) & rst_n;

    rr_burst_arbiter #(
        .n_ch      (n_ch),
        .burst_len (burst_len)
    ) u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .elig_i        (elig),
        .adv_i         (can_load),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign a_ready = grant;
    assign b_ready = grant;

    assign sel_base = 32'(grant_idx) * width;
    assign a_sel    = a_data[sel_base +: width];
    assign b_sel    = b_data[sel_base +: width];

`ifdef SUM_CHANNEL_ARBITER_SAT_EN
    logic [width:0] sum_full;
    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};
    assign sum_res  = sum_full[width] ? SatAllOnes[width-1:0] : sum_full[width-1:0];
`else
    assign sum_res = a_sel + b_sel;
`endif

    // A new beat overwrites a draining one in the same cycle, so no bubble.
    always_comb begin
        sum_valid_d = sum_valid_q & ~sum_ready;
        sum_data_d  = sum_data_q;
        sum_ch_d    = sum_ch_q;
        if (grant_valid) begin
            sum_valid_d = 1'b1;
            sum_data_d  = sum_res;
            sum_ch_d    = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid_q <= 1'b0;
            sum_data_q  <= '0;
            sum_ch_q    <= '0;
        end else begin
            sum_valid_q <= sum_valid_d;
            sum_data_q  <= sum_data_d;
            sum_ch_q    <= sum_ch_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign sum_ch    = sum_ch_q;

endmodule
